patch_embedding: RTL

PATCH_EMBEDDING -- requirements
Module: patch_embedding

---
 rtl/patch_embedding.sv | 119 +++++++++++
 1 files changed

// File: rtl/patch_embedding.sv
// Patch projection Y[t][e] = sat((b[e]<<F + sum_p X[t][p]*W[p][e]) >>> F), one MAC per cycle.
// Latency 1+NUM_TOKENS*E*(PATCH_DIM+1) cycles from start to done; no backpressure, start ignored while busy.
module patch_embedding #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_TOKENS = 196,
    parameter int PATCH_DIM  = 48,
    parameter int E          = 128,
    parameter int FRAC_BITS  = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    input  logic [DATA_WIDTH*NUM_TOKENS*PATCH_DIM-1:0] patches_in,
    input  logic [DATA_WIDTH*PATCH_DIM*E-1:0]        w_in,
    input  logic [DATA_WIDTH*E-1:0]                  bias_in,
    output logic [DATA_WIDTH*NUM_TOKENS*E-1:0]       out_embed,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     out_valid
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = 2*DW + $clog2(PATCH_DIM) + 1;
    localparam int TW = (NUM_TOKENS > 1) ? $clog2(NUM_TOKENS) : 1;
    localparam int EW = (E > 1) ? $clog2(E) : 1;
    localparam int PW = (PATCH_DIM > 1) ? $clog2(PATCH_DIM) : 1;

    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

    state_t                 state;
    logic [TW-1:0]          t;
    logic [EW-1:0]          e;
    logic [PW-1:0]          p;
    logic signed [AW-1:0]   acc;

    logic signed [DW-1:0]   x_el, w_el, res;
    logic [DW-1:0]          b_next;
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   prod_ext, shifted, bias_next_acc;
    logic [EW-1:0]          e_next;
    logic                   e_last, t_last, p_last;

    function automatic logic signed [AW-1:0] bias_acc(input logic [DW-1:0] b);
        logic signed [AW-1:0] ext;
        ext = {{(AW-DW){b[DW-1]}}, b};
        return ext <<< FRAC_BITS;
    endfunction

    always_comb begin
        x_el     = patches_in[(int'(t)*PATCH_DIM + int'(p))*DW +: DW];
        w_el     = w_in[(int'(p)*E + int'(e))*DW +: DW];
        prod     = $signed({{DW{x_el[DW-1]}}, x_el}) * $signed({{DW{w_el[DW-1]}}, w_el});
        prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
        e_last   = (e == EW'(E-1));
        t_last   = (t == TW'(NUM_TOKENS-1));
        p_last   = (p == PW'(PATCH_DIM-1));
        e_next   = e_last ? '0 : e + EW'(1);
        b_next   = bias_in[int'(e_next)*DW +: DW];
        bias_next_acc = bias_acc(b_next);
        shifted  = acc >>> FRAC_BITS;
        // In range only when every bit above the result's sign bit matches it.
        if ((&shifted[AW-1:DW-1]) || !(|shifted[AW-1:DW-1]))
            res = shifted[DW-1:0];
        else if (shifted[AW-1])
            res = {1'b1, {(DW-1){1'b0}}};
        else
            res = {1'b0, {(DW-1){1'b1}}};
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            t         <= '0;
            e         <= '0;
            p         <= '0;
            acc       <= '0;
            out_embed <= '0;
            done      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= MAC;
                        t         <= '0;
                        e         <= '0;
                        p         <= '0;
                        acc       <= bias_acc(bias_in[DW-1:0]);
                        out_valid <= 1'b0;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    if (p_last)
                        state <= WRITE;
                    else
                        p <= p + PW'(1);
                end
                WRITE: begin
                    out_embed[(int'(t)*E + int'(e))*DW +: DW] <= res;
                    p   <= '0;
                    acc <= bias_next_acc;
                    e   <= e_next;
                    if (e_last)
                        t <= t + TW'(1);
                    state <= (t_last && e_last) ? DONE : MAC;
                end
                DONE: begin
                    done      <= 1'b1;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
